// File: rtl/chip_7458_bist_pkg.sv
// rtl/chip_7458_bist_pkg.sv - shared state encodings and drive-bit map for the chip_7458 BIST
package chip_7458_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int P1A_BIT = 0;
  localparam int P1B_BIT = 1;
  localparam int P1C_BIT = 2;
  localparam int P1D_BIT = 3;
  localparam int P1E_BIT = 4;
  localparam int P1F_BIT = 5;
  localparam int P2A_BIT = 6;
  localparam int P2B_BIT = 7;
  localparam int P2C_BIT = 8;
  localparam int P2D_BIT = 9;

  localparam int         NUM_VECTORS = 1024;
  localparam logic [9:0] LAST_IDX    = 10'(NUM_VECTORS - 1);

endpackage

// File: rtl/chip_7458_golden.sv
// rtl/chip_7458_golden.sv - combinational reference model of the chip_7458 AND-OR gates
module chip_7458_golden
  import chip_7458_bist_pkg::*;
(
  input  logic [9:0] i_drv,
  output logic [1:0] o_exp_y
);

  logic w_p1_abc;
  logic w_p1_def;
  logic w_p2_ab;
  logic w_p2_cd;

  assign w_p1_abc = i_drv[P1A_BIT] & i_drv[P1B_BIT] & i_drv[P1C_BIT];
  assign w_p1_def = i_drv[P1D_BIT] & i_drv[P1E_BIT] & i_drv[P1F_BIT];
  assign w_p2_ab  = i_drv[P2A_BIT] & i_drv[P2B_BIT];
  assign w_p2_cd  = i_drv[P2C_BIT] & i_drv[P2D_BIT];

  assign o_exp_y[0] = w_p1_abc | w_p1_def;
  assign o_exp_y[1] = w_p2_ab | w_p2_cd;

endmodule

// File: rtl/chip_7458_bist.sv
// rtl/chip_7458_bist.sv - exhaustive 1024-vector self-test sequencer for a chip_7458 instance
module chip_7458_bist
  import chip_7458_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 11
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  output logic [9:0]       o_drv,
  input  logic [1:0]       i_dut_y,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_err_count,
  output logic             o_first_err_valid,
  output logic [9:0]       o_first_err_idx
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_t           r_state;
  logic [9:0]       r_idx;
  logic [3:0]       r_settle;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [CNT_W-1:0] r_err_count;
  logic             r_first_err_valid;
  logic [9:0]       r_first_err_idx;

  logic [1:0]       w_exp_y;
  logic             w_mismatch;
  logic [CNT_W-1:0] w_err_next;

  chip_7458_golden u_golden (
    .i_drv   (r_idx),
    .o_exp_y (w_exp_y)
  );

  assign w_mismatch = (i_dut_y != w_exp_y);
  // Saturating count: a full-scale counter simply stops incrementing.
  assign w_err_next = (w_mismatch && !(&r_err_count)) ? r_err_count + 1'b1 : r_err_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state           <= ST_IDLE;
      r_idx             <= '0;
      r_settle          <= '0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
      r_err_count       <= '0;
      r_first_err_valid <= 1'b0;
      r_first_err_idx   <= '0;
    end else if (r_busy && i_abort) begin
      // Abort drops the run but keeps results gathered so far for inspection.
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_state           <= ST_APPLY;
            r_idx             <= '0;
            r_busy            <= 1'b1;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_err_count       <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_idx   <= '0;
          end
        end
        ST_APPLY: begin
          r_state  <= ST_SETTLE;
          r_settle <= SETTLE_INIT;
        end
        ST_SETTLE: begin
          if (r_settle == 4'd0) begin
            r_state <= ST_CHECK;
          end else begin
            r_settle <= r_settle - 4'd1;
          end
        end
        ST_CHECK: begin
          r_err_count <= w_err_next;
          if (w_mismatch && !r_first_err_valid) begin
            r_first_err_valid <= 1'b1;
            r_first_err_idx   <= r_idx;
          end
          if (r_idx == LAST_IDX) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else begin
            r_state <= ST_APPLY;
            r_idx   <= r_idx + 10'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign o_drv             = r_idx;
  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_pass            = r_pass;
  assign o_err_count       = r_err_count;
  assign o_first_err_valid = r_first_err_valid;
  assign o_first_err_idx   = r_first_err_idx;

endmodule
